reg_dep_tracker: RTL and testbench
==================================

// Module: reg_dep_tracker
//
// PURPOSE
// Pipeline register-dependency tracker: successor to the fixed 5-bit register-equality check.
// Holds a shift register of in-flight destination tags, one entry per downstream stage.
// Compares every source operand of the instruction in decode against those tags.
// Produces per-operand forwarding selects, a load-use stall and a stall count; sits between decode and the operand muxes.
//
// PARAMETERS
// REG_W       5   register-number width (2**REG_W architectural regs; reg 0 hardwired zero)
// DEPTH       3   tracked downstream stages (entry 0 = youngest, e.g. EX; DEPTH-1 = oldest, e.g. WB)
// N_SRC       2   source operands compared per issued instruction
// LOAD_AVAIL  1   lowest entry index from which load data is forwardable (0..DEPTH-1)
// CNT_W       16  stall-counter width
//
// PORTS
// clk          in   1             clock, rising edge
// rst_n        in   1             asynchronous reset, active low
// issue_valid  in   1             decode presents an instruction
// issue_ready  out  1             = ~stall; issue accepted when issue_valid & issue_ready
// issue_rd     in   REG_W         destination register of issued instruction
// issue_wen    in   1             instruction writes issue_rd
// issue_load   in   1             instruction is a load
// src_reg      in   N_SRC*REG_W   source registers, operand i at [i*REG_W +: REG_W]
// src_used     in   N_SRC         operand i actually read
// flush        in   1             kill all tracked entries (branch/exception)
// stall        out  1             load-use hazard on an used operand
// fwd_sel      out  N_SRC*SEL_W   per operand: 0 = regfile, k = forward from entry k-1; SEL_W = clog2(DEPTH+1)
// stall_cnt    out  CNT_W         saturating count of stalled issue cycles
//
// BEHAVIOUR
// - Entry = {valid, rd, load}; valid only if producer had issue_wen=1 and rd != 0.
// - Reset (async, rst_n=0): all entries invalid, stall_cnt=0 -> stall=0, issue_ready=1, fwd_sel=0.
// - Each edge, no flush: entry[k] <= entry[k-1] for k>=1 (older stages always advance).
//   entry[0] <= issued instr if issue_valid & ~stall, else bubble (valid=0).
// - flush=1: all entries invalid at next edge; concurrent issue discarded; flush beats stall/issue.
// - Match(i,k): src_used[i] & entry[k].valid & src_reg[i]==entry[k].rd & src_reg[i]!=0.
// - Youngest match wins (lowest k); fwd_sel[i] = k+1, or 0 if no match. Combinational from
//   registered state + current inputs; zero cycles latency.
// - stall = OR over i of (youngest match k < LOAD_AVAIL and entry[k].load). Outputs during
//   stall still show fwd_sel; consumer ignores them.
// - stall_cnt increments on edges with issue_valid & stall & ~flush; saturates at all-ones, never wraps.
// - Duplicate tags across entries legal; only youngest used. Both operands same reg: identical selects.
// - issue_rd==0 or issue_wen=0: entry pushed invalid (bubble) but instruction still accepted.
// - Reset mid-stall: stall drops immediately with rst_n; no state survives.
//
// STRUCTURE
// - Shared include dep_pkg: REG_W default, SEL_W function (clog2), entry field offsets, FWD_RF=0.
// - Sub-module reg_tag_match #(REG_W): tag/valid/used compare with reg-0 exclusion; N_SRC*DEPTH
//   instances via generate. Priority encoder and shift register stay in top.
// - One always block, async-reset, for entries and stall_cnt; rest combinational.
//
// TESTING (defaults unless noted)
// 1 ALU chain: issue rd=3; next cycle src0=3 -> fwd_sel0=1, stall=0; cycle after (no reissue) -> 2.
// 2 Load-use: issue load rd=7; next src1=7 -> stall=1 one cycle, bubble inserted, then fwd_sel1=2, stall=0, stall_cnt=1.
// 3 Reg zero / unused: producer rd=0, src0=0 -> fwd_sel0=0; producer rd=4, src_used=0 -> no stall, fwd 0.
// 4 Priority: rd=5 issued twice back-to-back; src0=5 -> fwd_sel0=1 (youngest), not 2.
// 5 Flush + issue same cycle with pending load rd=9 -> next cycle all invalid, src=9 gives fwd 0, stall 0.
// 6 Async reset mid-stall, then saturation with CNT_W=2: 5 stalled cycles -> stall_cnt holds 3.

Source files
------------

// File: rtl/reg_dep_tracker_pkg.sv
// Shared constants and helpers for the register-dependency tracker.
// Entry packing is {valid, rd, load} with load in bit 0.
package reg_dep_tracker_pkg;

    localparam int REG_W_DEF    = 5;
    localparam int FWD_RF       = 0;
    localparam int ENT_LOAD_BIT = 0;
    localparam int ENT_RD_LSB   = 1;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ent_valid_bit(input int reg_w);
        return reg_w + 1;
    endfunction

endpackage

// File: rtl/reg_dep_tracker_if.sv
// Decode-side issue/operand bundle between decode and the dependency tracker.
interface reg_dep_tracker_if #(
    parameter int REG_W = 5,
    parameter int N_SRC = 2,
    parameter int SEL_W = 2
);
    logic                     issue_valid;
    logic                     issue_ready;
    logic [REG_W-1:0]         issue_rd;
    logic                     issue_wen;
    logic                     issue_load;
    logic [N_SRC*REG_W-1:0]   src_reg;
    logic [N_SRC-1:0]         src_used;
    logic                     stall;
    logic [N_SRC*SEL_W-1:0]   fwd_sel;

    modport master (
        output issue_valid, issue_rd, issue_wen, issue_load, src_reg, src_used,
        input  issue_ready, stall, fwd_sel
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wen, issue_load, src_reg, src_used,
        output issue_ready, stall, fwd_sel
    );
endinterface

// File: rtl/reg_dep_tracker_tag_match.sv
// One operand-vs-tag comparator; register 0 never matches since it reads as zero.
module reg_tag_match #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_reg,
    input  logic             src_used,
    input  logic             tag_valid,
    input  logic [REG_W-1:0] tag_rd,
    output logic             hit
);
    assign hit = src_used && tag_valid && (src_reg == tag_rd) && (src_reg != '0);
endmodule

// File: rtl/reg_dep_tracker.sv
// In-flight destination tag shift register with per-operand forwarding select,
// load-use stall generation and a saturating stall-cycle counter.
module reg_dep_tracker
    import reg_dep_tracker_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int DEPTH      = 3,
    parameter int N_SRC      = 2,
    parameter int LOAD_AVAIL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    reg_dep_tracker_if.slave dep
);
    localparam int SEL_W = sel_w(DEPTH);
    localparam int ENT_W = REG_W + 2;
    localparam int VBIT  = ent_valid_bit(REG_W);

    logic [ENT_W-1:0] entry_reg [DEPTH];
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [DEPTH-1:0] match [N_SRC];
    logic [N_SRC-1:0] op_stall;
    logic             stall;
    logic             accept;
    logic [ENT_W-1:0] entry0_next;

    genvar gi, gk;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            for (gk = 0; gk < DEPTH; gk++) begin : g_stage
                reg_tag_match #(.REG_W(REG_W)) u_match (
                    .src_reg   (dep.src_reg[gi*REG_W +: REG_W]),
                    .src_used  (dep.src_used[gi]),
                    .tag_valid (entry_reg[gk][VBIT]),
                    .tag_rd    (entry_reg[gk][ENT_RD_LSB +: REG_W]),
                    .hit       (match[gi][gk])
                );
            end

            // Scan oldest to youngest so the youngest hit is the one left standing.
            logic [SEL_W-1:0] sel;
            always_comb begin
                sel          = SEL_W'(FWD_RF);
                op_stall[gi] = 1'b0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (match[gi][k]) begin
                        sel          = SEL_W'(k + 1);
                        op_stall[gi] = (k < LOAD_AVAIL) && entry_reg[k][ENT_LOAD_BIT];
                    end
                end
            end
            assign dep.fwd_sel[gi*SEL_W +: SEL_W] = sel;
        end
    endgenerate

    assign stall           = |op_stall;
    assign dep.stall       = stall;
    assign dep.issue_ready = ~stall;
    assign stall_cnt       = stall_cnt_reg;
    assign accept          = dep.issue_valid && !stall;
    assign entry0_next     = {accept && dep.issue_wen && (dep.issue_rd != '0),
                              dep.issue_rd, dep.issue_load};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) entry_reg[k] <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) entry_reg[k] <= '0;
            end else begin
                for (int k = 1; k < DEPTH; k++) entry_reg[k] <= entry_reg[k-1];
                entry_reg[0] <= entry0_next;
            end
            if (dep.issue_valid && stall && !flush && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_dep_tracker.sv
// Randomized and directed checks of reg_dep_tracker against a pipeline-list model.
module tb_reg_dep_tracker;
    localparam int REG_W = 5, DEPTH = 3, N_SRC = 2, LOAD_AVAIL = 1;
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_sat;

    always #5 clk = ~clk;

    reg_dep_tracker_if #(.REG_W(REG_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) dep_if ();
    reg_dep_tracker_if #(.REG_W(REG_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) sat_if ();

    assign sat_if.issue_valid = dep_if.issue_valid;
    assign sat_if.issue_rd    = dep_if.issue_rd;
    assign sat_if.issue_wen   = dep_if.issue_wen;
    assign sat_if.issue_load  = dep_if.issue_load;
    assign sat_if.src_reg     = dep_if.src_reg;
    assign sat_if.src_used    = dep_if.src_used;

    reg_dep_tracker #(.REG_W(REG_W), .DEPTH(DEPTH), .N_SRC(N_SRC),
                      .LOAD_AVAIL(LOAD_AVAIL), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_cnt(stall_cnt), .dep(dep_if));

    reg_dep_tracker #(.REG_W(REG_W), .DEPTH(DEPTH), .N_SRC(N_SRC),
                      .LOAD_AVAIL(LOAD_AVAIL), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_cnt(stall_cnt_sat), .dep(sat_if));

    // Model: list of in-flight producers, index 0 youngest.
    bit m_valid [DEPTH];
    int m_rd    [DEPTH];
    bit m_load  [DEPTH];
    int m_cnt16, m_cnt2;
    int exp_sel [N_SRC];
    bit exp_stall;
    int n_checks = 0, n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_valid[k] = 0; m_rd[k] = 0; m_load[k] = 0;
        end
        m_cnt16 = 0; m_cnt2 = 0;
    endtask

    task automatic model_eval();
        logic [N_SRC*REG_W-1:0] srcs;
        srcs = dep_if.src_reg;
        exp_stall = 0;
        for (int i = 0; i < N_SRC; i++) begin
            int r;
            r = int'(srcs[i*REG_W +: REG_W]);
            exp_sel[i] = 0;
            for (int k = 0; k < DEPTH; k++)
                if (exp_sel[i] == 0 && dep_if.src_used[i] && m_valid[k] && m_rd[k] == r && r != 0)
                    exp_sel[i] = k + 1;
            if (exp_sel[i] != 0 && (exp_sel[i] - 1) < LOAD_AVAIL && m_load[exp_sel[i] - 1])
                exp_stall = 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [N_SRC*SEL_W-1:0] f;
        model_eval();
        f = dep_if.fwd_sel;
        for (int i = 0; i < N_SRC; i++)
            check_val($sformatf("%s_fwd%0d", tag, i), 32'(f[i*SEL_W +: SEL_W]), 32'(exp_sel[i]));
        check_val({tag, "_stall"}, 32'(dep_if.stall), 32'(exp_stall));
        check_val({tag, "_ready"}, 32'(dep_if.issue_ready), 32'(!exp_stall));
        check_val({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt16));
        check_val({tag, "_cnt2"}, 32'(stall_cnt_sat), 32'(m_cnt2));
        $display("%s v=%0b rd=%0d wen=%0b ld=%0b src=%0h used=%0b fl=%0b -> fwd=%0h stall=%0b cnt=%0d",
                 tag, dep_if.issue_valid, dep_if.issue_rd, dep_if.issue_wen, dep_if.issue_load,
                 dep_if.src_reg, dep_if.src_used, flush, dep_if.fwd_sel, dep_if.stall, stall_cnt);
    endtask

    task automatic apply(input string tag, input bit v, input int rd, input bit wen, input bit ld,
                         input int s0, input int s1, input logic [1:0] used, input bit fl);
        dep_if.issue_valid = v;
        dep_if.issue_rd    = REG_W'(rd);
        dep_if.issue_wen   = wen;
        dep_if.issue_load  = ld;
        dep_if.src_reg     = {REG_W'(s1), REG_W'(s0)};
        dep_if.src_used    = used;
        flush              = fl;
        #1;
        check_model(tag);
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = dep_if.issue_valid && !exp_stall;
        if (dep_if.issue_valid && exp_stall && !flush) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) m_valid[k] = 0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                m_valid[k] = m_valid[k-1]; m_rd[k] = m_rd[k-1]; m_load[k] = m_load[k-1];
            end
            m_valid[0] = acc && dep_if.issue_wen && (dep_if.issue_rd != 0);
            m_rd[0]    = int'(dep_if.issue_rd);
            m_load[0]  = dep_if.issue_load;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        dep_if.issue_valid = 0; dep_if.issue_rd = '0; dep_if.issue_wen = 0;
        dep_if.issue_load = 0; dep_if.src_reg = '0; dep_if.src_used = '0;
        repeat (2) @(negedge clk);
        apply("rst", 0, 0, 0, 0, 3, 3, 2'b11, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU chain
        apply("t1_iss", 1, 3, 1, 0, 0, 0, 2'b00, 0); tick();
        apply("t1_c1", 0, 0, 0, 0, 3, 0, 2'b01, 0);
        check_val("t1_fwd_ex", 32'(dep_if.fwd_sel[0 +: SEL_W]), 1); tick();
        apply("t1_c2", 0, 0, 0, 0, 3, 0, 2'b01, 0);
        check_val("t1_fwd_mem", 32'(dep_if.fwd_sel[0 +: SEL_W]), 2); tick();

        // Load-use
        apply("t2_ld", 1, 7, 1, 1, 0, 0, 2'b00, 0); tick();
        apply("t2_use", 1, 0, 0, 0, 0, 7, 2'b10, 0);
        check_val("t2_stall", 32'(dep_if.stall), 1); tick();
        apply("t2_rel", 1, 0, 0, 0, 0, 7, 2'b10, 0);
        check_val("t2_stall_rel", 32'(dep_if.stall), 0);
        check_val("t2_fwd1", 32'(dep_if.fwd_sel[SEL_W +: SEL_W]), 2);
        check_val("t2_cnt", 32'(stall_cnt), 1); tick();

        // Register zero and unused operand
        apply("t3_r0", 1, 0, 1, 0, 0, 0, 2'b00, 0); tick();
        apply("t3_src0", 0, 0, 0, 0, 0, 0, 2'b01, 0);
        check_val("t3_fwd_r0", 32'(dep_if.fwd_sel[0 +: SEL_W]), 0);
        apply("t3_ld4", 1, 4, 1, 1, 0, 0, 2'b00, 0); tick();
        apply("t3_unused", 1, 0, 0, 0, 4, 0, 2'b00, 0);
        check_val("t3_nostall", 32'(dep_if.stall), 0);
        check_val("t3_fwd_unused", 32'(dep_if.fwd_sel[0 +: SEL_W]), 0); tick();

        // Youngest wins
        apply("t4_a", 1, 5, 1, 0, 0, 0, 2'b00, 0); tick();
        apply("t4_b", 1, 5, 1, 0, 0, 0, 2'b00, 0); tick();
        apply("t4_use", 0, 0, 0, 0, 5, 5, 2'b11, 0);
        check_val("t4_prio0", 32'(dep_if.fwd_sel[0 +: SEL_W]), 1);
        check_val("t4_prio1", 32'(dep_if.fwd_sel[SEL_W +: SEL_W]), 1); tick();

        // Flush with concurrent issue over a pending load
        apply("t5_ld", 1, 9, 1, 1, 0, 0, 2'b00, 0); tick();
        apply("t5_fl", 1, 9, 1, 1, 9, 0, 2'b01, 1); tick();
        apply("t5_after", 0, 0, 0, 0, 9, 9, 2'b11, 0);
        check_val("t5_fwd", 32'(dep_if.fwd_sel), 0);
        check_val("t5_stall", 32'(dep_if.stall), 0); tick();

        // Async reset mid-stall
        apply("t6_ld", 1, 10, 1, 1, 0, 0, 2'b00, 0); tick();
        apply("t6_use", 1, 0, 0, 0, 10, 0, 2'b01, 0);
        check_val("t6_pre", 32'(dep_if.stall), 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("t6_rst_stall", 32'(dep_if.stall), 0);
        check_val("t6_rst_ready", 32'(dep_if.issue_ready), 1);
        check_val("t6_rst_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Repeated load-use drives the narrow counter into saturation
        for (int n = 0; n < 12; n++) begin
            apply("t6_sat", 1, 11, 1, 1, 11, 0, 2'b01, 0); tick();
        end
        check_val("t6_sat_hold", 32'(stall_cnt_sat), 3);

        // Random traffic on a small register window so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            apply("rnd", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
